// File: rtl/seg_pkg.sv
// Shared glyph table and leading-zero helper for the seven-segment scanner.
// Glyph bit 0 is segment a, bit 6 is segment g; glyphs are active-high.
package seg_pkg;

  typedef logic [6:0] glyph_t;

  localparam glyph_t GLYPH_0 = 7'h3F;
  localparam glyph_t GLYPH_1 = 7'h06;
  localparam glyph_t GLYPH_2 = 7'h5B;
  localparam glyph_t GLYPH_3 = 7'h4F;
  localparam glyph_t GLYPH_4 = 7'h66;
  localparam glyph_t GLYPH_5 = 7'h6D;
  localparam glyph_t GLYPH_6 = 7'h7D;
  localparam glyph_t GLYPH_7 = 7'h07;
  localparam glyph_t GLYPH_8 = 7'h7F;
  localparam glyph_t GLYPH_9 = 7'h6F;
  localparam glyph_t GLYPH_A = 7'h77;
  localparam glyph_t GLYPH_B = 7'h7C;
  localparam glyph_t GLYPH_C = 7'h39;
  localparam glyph_t GLYPH_D = 7'h5E;
  localparam glyph_t GLYPH_E = 7'h79;
  localparam glyph_t GLYPH_F = 7'h71;

  // Bit i set when digit i (i > 0) and every more-significant digit up to
  // n_digits-1 are zero. Digit 0 is never flagged.
  function automatic logic [7:0] lzb_mask(input logic [31:0] nibbles,
                                          input int unsigned n_digits);
    logic [7:0] mask;
    logic       zero_run;
    mask     = '0;
    zero_run = 1'b1;
    for (int unsigned i = 7; i >= 1; i--) begin
      if (i < n_digits) begin
        zero_run = zero_run && (nibbles[i*4 +: 4] == 4'h0);
        mask[i]  = zero_run;
      end
    end
    return mask;
  endfunction

endpackage

// File: rtl/seg_decode.sv
// Combinational hex nibble to active-high seven-segment glyph.
module seg_decode
  import seg_pkg::*;
(
  input  logic [3:0] nibble_i,
  output glyph_t     glyph_o
);

  always_comb begin
    glyph_o = GLYPH_0;
    unique case (nibble_i)
      4'h0: glyph_o = GLYPH_0;
      4'h1: glyph_o = GLYPH_1;
      4'h2: glyph_o = GLYPH_2;
      4'h3: glyph_o = GLYPH_3;
      4'h4: glyph_o = GLYPH_4;
      4'h5: glyph_o = GLYPH_5;
      4'h6: glyph_o = GLYPH_6;
      4'h7: glyph_o = GLYPH_7;
      4'h8: glyph_o = GLYPH_8;
      4'h9: glyph_o = GLYPH_9;
      4'hA: glyph_o = GLYPH_A;
      4'hB: glyph_o = GLYPH_B;
      4'hC: glyph_o = GLYPH_C;
      4'hD: glyph_o = GLYPH_D;
      4'hE: glyph_o = GLYPH_E;
      4'hF: glyph_o = GLYPH_F;
    endcase
  end

endmodule

// File: rtl/seg_scan.sv
// Multiplexed seven-segment scanner with frame-synchronous display update.
// Define SEG_SCAN_LZB_EN to blank leading zeros (digit 0 always shown).
module seg_scan
  import seg_pkg::*;
#(
  parameter int unsigned N_DIGITS   = 4,
  parameter int unsigned DIV        = 100000,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4*N_DIGITS-1:0] value,
  input  logic                  load,
  input  logic [N_DIGITS-1:0]   dp_mask,
  input  logic                  blank,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [N_DIGITS-1:0]   an
);

  localparam int unsigned CntW = $clog2(DIV);
  localparam int unsigned IdxW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  logic [CntW-1:0]       cnt_q;
  logic [IdxW-1:0]       idx_q;
  logic [4*N_DIGITS-1:0] shadow_val_q, disp_val_q;
  logic [N_DIGITS-1:0]   shadow_dp_q, disp_dp_q;
  logic [6:0]            seg_q;
  logic                  dp_q;
  logic [N_DIGITS-1:0]   an_q;

  logic                tick, frame;
  logic [3:0]          nibble;
  logic                dp_bit, lzb_bit;
  logic [7:0]          lzb_all;
  logic [N_DIGITS-1:0] onehot;
  glyph_t              glyph;
  logic [6:0]          seg_d;
  logic                dp_d;
  logic [N_DIGITS-1:0] an_d;

  assign tick  = (cnt_q == CntW'(DIV - 1));
  assign frame = tick && (idx_q == IdxW'(N_DIGITS - 1));

`ifdef SEG_SCAN_LZB_EN
  assign lzb_all = lzb_mask(32'(disp_val_q), N_DIGITS);
`else
  assign lzb_all = '0;
`endif

  always_comb begin
    nibble  = 4'h0;
    dp_bit  = 1'b0;
    lzb_bit = 1'b0;
    onehot  = '0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (idx_q == IdxW'(i)) begin
        nibble    = disp_val_q[i*4 +: 4];
        dp_bit    = disp_dp_q[i];
        lzb_bit   = lzb_all[i];
        onehot[i] = 1'b1;
      end
    end
  end

  seg_decode u_decode (
    .nibble_i (nibble),
    .glyph_o  (glyph)
  );

  // The cycle after a tick is dark so the previous digit cannot ghost onto
  // the next anode; a blanked leading zero keeps its anode only for the dp.
  always_comb begin
    logic dark;
    dark  = tick || blank;
    an_d  = (!dark && !(lzb_bit && !dp_bit)) ? onehot : '0;
    seg_d = (!dark && !lzb_bit) ? glyph : 7'h00;
    dp_d  = !dark && dp_bit;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      shadow_val_q <= '0;
      shadow_dp_q  <= '0;
      disp_val_q   <= '0;
      disp_dp_q    <= '0;
      seg_q        <= {7{ACTIVE_LOW}};
      dp_q         <= ACTIVE_LOW;
      an_q         <= {N_DIGITS{ACTIVE_LOW}};
    end else begin
      cnt_q <= tick ? '0 : cnt_q + 1'b1;
      if (tick) begin
        idx_q <= frame ? '0 : idx_q + 1'b1;
      end
      if (load) begin
        shadow_val_q <= value;
        shadow_dp_q  <= dp_mask;
      end
      if (frame) begin
        disp_val_q <= load ? value : shadow_val_q;
        disp_dp_q  <= load ? dp_mask : shadow_dp_q;
      end
      seg_q <= seg_d ^ {7{ACTIVE_LOW}};
      dp_q  <= dp_d ^ ACTIVE_LOW;
      an_q  <= an_d ^ {N_DIGITS{ACTIVE_LOW}};
    end
  end

  assign seg = seg_q;
  assign dp  = dp_q;
  assign an  = an_q;

endmodule

// File: tb/tb_seg_scan.sv
// Directed bench for seg_scan with DIV=4, N_DIGITS=4, active-low outputs.
// Expectations adapt when SEG_SCAN_LZB_EN is defined.
module tb_seg_scan;

`ifdef SEG_SCAN_LZB_EN
  localparam bit Lzb = 1'b1;
`else
  localparam bit Lzb = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        load = 1'b0;
  logic        blank = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  dp_mask = '0;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;

  int cyc = 0;
  int n_checks = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  seg_scan #(
    .N_DIGITS   (4),
    .DIV        (4),
    .ACTIVE_LOW (1'b1)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .value   (value),
    .load    (load),
    .dp_mask (dp_mask),
    .blank   (blank),
    .seg     (seg),
    .dp      (dp),
    .an      (an)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got 'h%0h expected 'h%0h (cycle %0d)", tag, got, exp, cyc);
    end else begin
      n_pass++;
    end
  endtask

  task automatic chk_out(input string tag, input logic [3:0] e_an, input logic [6:0] e_seg,
                         input logic e_dp);
    check({tag, ".an"}, 32'(an), 32'(e_an));
    check({tag, ".seg"}, 32'(seg), 32'(e_seg));
    check({tag, ".dp"}, 32'(dp), 32'(e_dp));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic goto(input int k);
    while (cyc < k) step();
  endtask

  initial begin
    step(); step(); step();
    cyc = 0;
    chk_out("reset", 4'hF, 7'h7F, 1'b1);
    reset = 1'b0;

    goto(1);  chk_out("first_digit0", 4'hE, 7'h40, 1'b1);
    goto(4);  chk_out("first_dead", 4'hF, 7'h7F, 1'b1);
    goto(5);  chk_out("digit1_zero", Lzb ? 4'hF : 4'hD, Lzb ? 7'h7F : 7'h40, 1'b1);
    value = 16'hFFFF; load = 1'b1;
    goto(6);  load = 1'b0;
    goto(7);  value = 16'h12AF; load = 1'b1;
    goto(8);  load = 1'b0;
    goto(9);  chk_out("old_digit2", Lzb ? 4'hF : 4'hB, Lzb ? 7'h7F : 7'h40, 1'b1);
    goto(13); chk_out("old_digit3", Lzb ? 4'hF : 4'h7, Lzb ? 7'h7F : 7'h40, 1'b1);
    goto(16); chk_out("frame_dead", 4'hF, 7'h7F, 1'b1);
    goto(17); chk_out("new_d0_F", 4'hE, 7'h0E, 1'b1);
    goto(21); chk_out("new_d1_A", 4'hD, 7'h08, 1'b1);
    goto(25); chk_out("new_d2_2", 4'hB, 7'h24, 1'b1);
    goto(29); chk_out("new_d3_1", 4'h7, 7'h79, 1'b1);

    goto(45); chk_out("held_d3_1", 4'h7, 7'h79, 1'b1);
    goto(47); value = 16'h0005; dp_mask = 4'b0001; load = 1'b1;
    goto(48); load = 1'b0; value = 16'hBEEF; dp_mask = 4'b0000;
    goto(49); chk_out("bound_d0_5", 4'hE, 7'h12, 1'b0);

    goto(50); chk_out("pre_blank", 4'hE, 7'h12, 1'b0);
    blank = 1'b1;
    goto(51); chk_out("blank_a", 4'hF, 7'h7F, 1'b1);
    goto(55); chk_out("blank_b", 4'hF, 7'h7F, 1'b1);
    goto(60); chk_out("blank_c", 4'hF, 7'h7F, 1'b1);
    blank = 1'b0;
    goto(61); chk_out("unblank_d3", Lzb ? 4'hF : 4'h7, Lzb ? 7'h7F : 7'h40, 1'b1);

    goto(65); value = 16'h4321; dp_mask = 4'hF; load = 1'b1;
    goto(66); load = 1'b0; reset = 1'b1;
    goto(67); chk_out("mid_reset", 4'hF, 7'h7F, 1'b1);
    value = 16'h9999; load = 1'b1;
    goto(68); load = 1'b0; reset = 1'b0;
    goto(69); chk_out("rst2_d0", 4'hE, 7'h40, 1'b1);
    goto(84); chk_out("rst2_dead", 4'hF, 7'h7F, 1'b1);
    goto(85); chk_out("rst2_frame_d0", 4'hE, 7'h40, 1'b1);
    goto(89); chk_out("rst2_frame_d1", Lzb ? 4'hF : 4'hD, Lzb ? 7'h7F : 7'h40, 1'b1);

    goto(99);  value = 16'h0030; dp_mask = 4'b1000; load = 1'b1;
    goto(100); load = 1'b0;
    goto(101); chk_out("lzb_d0", 4'hE, 7'h40, 1'b1);
    goto(105); chk_out("lzb_d1", 4'hD, 7'h30, 1'b1);
    goto(109); chk_out("lzb_d2", Lzb ? 4'hF : 4'hB, Lzb ? 7'h7F : 7'h40, 1'b1);
    goto(113); chk_out("lzb_d3", 4'h7, Lzb ? 7'h7F : 7'h40, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/seg_scan.md
SEG_SCAN -- requirements
Module: seg_scan

Interface
REQ-001 SHALL have parameter N_DIGITS, default 4: number of multiplexed digits, legal 1..8.
REQ-002 SHALL have parameter DIV, default 100000: clk cycles per digit slot, legal 2..2^20.
REQ-003 SHALL have parameter ACTIVE_LOW, default 1: when 1, seg, dp and an are active-low; when 0, active-high.
REQ-004 SHALL have port clk  in  1: the single clock; all logic is rising-edge.
REQ-005 SHALL have port reset  in  1: synchronous, active-high reset.
REQ-006 SHALL have port value  in  4*N_DIGITS: hex nibbles; nibble i drives digit i, where digit 0 is the rightmost.
REQ-007 SHALL have port load  in  1: one-cycle strobe that captures value and dp_mask.
REQ-008 SHALL have port dp_mask  in  N_DIGITS: decimal-point enable, one bit per digit.
REQ-009 SHALL have port blank  in  1: level input; while high, all digits are dark.
REQ-010 SHALL have port seg  out  7: segments a..g, where bit 0 is a.
REQ-011 SHALL have port dp  out  1: decimal point.
REQ-012 SHALL have port an  out  N_DIGITS: digit enables, one-hot when active.

Function
REQ-013 SHALL run a prescaler cnt from 0 to DIV-1, with tick high when cnt==DIV-1; on tick, cnt wraps to 0.
REQ-014 SHALL advance digit index idx on each tick, wrapping from N_DIGITS-1 to 0; the tick that wraps idx is the frame boundary.
REQ-015 SHALL, on load, capture value and dp_mask into a shadow register; a later load overwrites an earlier one, with no queueing.
REQ-016 SHALL copy the shadow into the display register only at a frame boundary, so a frame never mixes old and new data.
REQ-017 SHALL, when load coincides with a frame boundary, write the incoming value and dp_mask directly into the display register.
REQ-018 SHALL register all outputs, with one cycle of latency from idx, display register or blank to the pins.
REQ-019 SHALL drive all an inactive for exactly one cycle after every tick (dead cycle, anti-ghosting); seg and dp are inactive in that cycle.
REQ-020 SHALL, outside dead cycles, drive an[idx] active and all other an inactive.
REQ-021 SHALL drive seg with the hex glyph of display nibble idx; 0-F are all distinct and b/d are lowercase.
REQ-022 SHALL drive dp from dp_mask[idx] of the display register.
REQ-023 SHALL, while blank is high, force all an, seg and dp inactive one cycle later; cnt and idx keep running and load is still accepted.
REQ-024 SHALL perform width-exact arithmetic: cnt is $clog2(DIV) bits, idx is $clog2(N_DIGITS) bits with a minimum of 1, and no modular overflow beyond the explicit wrap.
REQ-025 SHALL, when N_DIGITS==1, keep idx at 0 and make every tick both a frame boundary and a dead cycle.

Reset
REQ-026 SHALL, on reset, clear cnt, idx, shadow and display registers to 0.
REQ-027 SHALL, on reset, drive all an, seg and dp inactive in the cycle following the reset edge.
REQ-028 SHALL, when reset is asserted mid-frame, discard any pending shadow update.
REQ-029 SHALL ignore load in cycles where reset is high.
REQ-030 SHALL, in the first cycle after reset deassertion, display digit 0 of all-zero data.

Configuration
REQ-031 SHALL, when SEG_SCAN_LZB_EN is defined, blank leading zeros: digit i is dark (an inactive, seg inactive) when all display nibbles i..N_DIGITS-1 are 0 and i>0.
REQ-032 SHALL, with SEG_SCAN_LZB_EN defined, always show digit 0, and still light dp on a digit blanked as a leading zero, with that digit's an active.
REQ-033 SHALL, when SEG_SCAN_LZB_EN is undefined, show every digit, including zeros.

Structure
REQ-034 SHALL take the 7-bit glyph table type, the glyph constants GLYPH_0..GLYPH_F and the helper function lzb_mask from shared package seg_pkg.
REQ-035 SHALL implement nibble-to-glyph conversion in combinational sub-module seg_decode (4-bit in, 7-bit active-high out); polarity inversion happens only in seg_scan.

Verification
REQ-036 SHALL verify, with DIV=4, N_DIGITS=4, ACTIVE_LOW=1: release reset -> cycle 1 an=4'b1110 and seg=glyph 0 inverted; first tick -> dead cycle an=4'b1111, then an=4'b1101.
REQ-037 SHALL verify: load value=16'h12AF mid-frame -> old data held until the frame boundary, then digits 0..3 show F, A, 2, 1 in order.
REQ-038 SHALL verify: load on the exact frame-boundary cycle with value=16'h0005 -> the next frame shows 5 on digit 0 with no stale frame.
REQ-039 SHALL verify: blank high for 10 cycles -> an=4'b1111 from one cycle after assertion until one cycle after release; idx keeps advancing.
REQ-040 SHALL verify, with SEG_SCAN_LZB_EN defined: value=16'h0030, dp_mask=4'b1000 -> digits 0 and 1 lit, digit 2 dark, digit 3 shows only dp.
REQ-041 SHALL verify: reset asserted with a load pending -> all outputs inactive, and after release the display shows 0, not the pending value.
